// File: rtl/sif_pkg.sv
// Shared types and constants for the small-interface (sif) write path.
// Holds the write-entry struct that travels from the interface block into
// the write buffer, plus the occupancy-width helper.
package sif_pkg;

    localparam int SIF_AW = 16;
    localparam int SIF_DW = 16;

    typedef struct packed {
        logic [SIF_AW-1:0] addr;
        logic [SIF_DW-1:0] data;
    } sif_wr_t;

    // Occupancy counter width: one bit wider than a pointer so that
    // 0 and DEPTH are both representable.
    function automatic int sif_occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sif_wbuf_mem.sv
// DEPTH x sif_wr_t register array for the write buffer.
// One synchronous write port and an asynchronous head read port.
// With SIF_WBUF_COALESCE_EN defined, a second asynchronous read port
// exposes an arbitrary entry so the top can compare against the tail.
module sif_wbuf_mem
    import sif_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  sif_wr_t       wdata,
    input  logic [PW-1:0] raddr,
    output sif_wr_t       rdata
`ifdef SIF_WBUF_COALESCE_EN
    ,
    input  logic [PW-1:0] taddr,
    output sif_wr_t       tdata
`endif
);

    sif_wr_t mem [DEPTH];

    // Write port: store the entry at the addressed slot.
    // NOTE: storage has no reset; validity is tracked by the pointers and
    // count, and leaving the array unreset lets it map onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

`ifdef SIF_WBUF_COALESCE_EN
    assign tdata = mem[taddr];
`endif

endmodule

// File: rtl/sif_wbuf.sv
// sif_wbuf: write-side FIFO buffer behind the small-interface block.
// Captures one-cycle write strobes and drains them in order to a slower
// target over a valid/ready handshake, with show-ahead head, occupancy
// count and a sticky overflow flag.
// Optional feature macro: SIF_WBUF_COALESCE_EN -- a write to the same
// address as the tail entry (when at least two entries are held)
// overwrites the tail data instead of allocating a new slot.
module sif_wbuf
    import sif_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SIF_AW,
    parameter int DW    = SIF_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wa_wr_s,
    input  logic [AW-1:0]              wa_addr,
    input  logic [DW-1:0]              wa_data_wr,
    output logic                       tg_valid,
    output logic [AW-1:0]              tg_addr,
    output logic [DW-1:0]              tg_data,
    input  logic                       tg_ready,
    output logic [sif_occ_w(DEPTH)-1:0] count,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = sif_occ_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          full;
    logic          coalesce;
    logic          accept;
    logic          ovf_set;
    logic          mem_we;
    logic [PW-1:0] mem_waddr;
    sif_wr_t       wr_entry;
    sif_wr_t       head;

`ifdef SIF_WBUF_COALESCE_EN
    logic [PW-1:0] tail_ptr;
    sif_wr_t       tail;

    assign tail_ptr = wr_ptr - PW'(1);
`endif

    assign wr_entry = '{addr: wa_addr, data: wa_data_wr};

    // Push/pop/coalesce decisions and next occupancy.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        push       = wa_wr_s;
        pop        = tg_valid & tg_ready;
        full       = (count == FULL);
        coalesce   = 1'b0;
`ifdef SIF_WBUF_COALESCE_EN
        coalesce   = push && (count >= CW'(2)) && (tail.addr == wa_addr);
`endif
        accept     = push & ~coalesce & (~full | pop);
        ovf_set    = push & ~coalesce & full & ~pop;
        mem_we     = accept | coalesce;
        mem_waddr  = wr_ptr;
`ifdef SIF_WBUF_COALESCE_EN
        if (coalesce) begin
            mem_waddr = tail_ptr;
        end
`endif
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointer, occupancy, head-valid and overflow state.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tg_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count_next;
            tg_valid <= (count_next != '0);
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    sif_wbuf_mem #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
`ifdef SIF_WBUF_COALESCE_EN
        ,
        .taddr (tail_ptr),
        .tdata (tail)
`endif
    );

    // Head is forced to zero while empty since the array is not reset.
    assign tg_addr = tg_valid ? head.addr : '0;
    assign tg_data = tg_valid ? head.data : '0;

endmodule
